// File: rtl/alu_cmd_issuer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_issuer_pkg
//  Description : Shared types for the ALU command issuer: datapath word and
//                byte types, ALU opcode enumeration, the queued command
//                record, issuer FSM states and an opcode legality helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_cmd_issuer_pkg;

    typedef logic [31:0] word_t;
    typedef logic [7:0]  byte_t;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        XOR = 3'd4,
        SLT = 3'd5
    } alu_op_t;

    // Highest legal opcode; 6 and 7 are reserved.
    localparam logic [2:0] ALU_OP_MAX = 3'd5;

    // Tag storage in the queued record. Issuers narrower than this
    // zero-extend on the way in and truncate on the way out.
    localparam int CMD_TAG_W = 8;

    // Opcode is kept as raw bits so reserved codes survive the queue.
    typedef struct packed {
        word_t                 a;
        word_t                 b;
        logic [2:0]            op;
        logic [CMD_TAG_W-1:0]  tag;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } issuer_state_t;

    function automatic logic is_reserved_op(input logic [2:0] op);
        return (op > ALU_OP_MAX);
    endfunction

endpackage : alu_cmd_issuer_pkg
`default_nettype wire

// File: rtl/alu_cmd_issuer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO of an arbitrary element type. Registered
//                storage, no write-to-read bypass: an entry written on one
//                edge is visible at rdata from the following cycle.
//  Ports       : clk, rst_n (sync, active low)
//                push/wdata  - write side, ignored while full
//                pop/rdata   - read side, rdata is the head, pop ignored
//                              while empty
//                full, empty - occupancy flags from the current pointers
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int         c_aw      = $clog2(DEPTH);
    localparam logic [c_aw:0] c_ptr_one = 1;

    T                mem_q [DEPTH];
    logic [c_aw:0]   wr_ptr_q;
    logic [c_aw:0]   wr_ptr_d;
    logic [c_aw:0]   rd_ptr_q;
    logic [c_aw:0]   rd_ptr_d;
    logic            w_do_push;
    logic            w_do_pop;

    // Extra MSB on each pointer distinguishes full from empty when the
    // index bits match.
    always_comb begin
        full      = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                    (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
        empty     = (wr_ptr_q == rd_ptr_q);
        w_do_push = push && !full;
        w_do_pop  = pop && !empty;
        wr_ptr_d  = w_do_push ? (wr_ptr_q + c_ptr_one) : wr_ptr_q;
        rd_ptr_d  = w_do_pop  ? (rd_ptr_q + c_ptr_one) : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q[c_aw-1:0]] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q[c_aw-1:0]];

endmodule : sync_fifo
`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_issuer
//  Description : Command-side master for the ALU. Queues requests, drives
//                registered operands/opcode to the ALU for one issue cycle,
//                captures result and zero flag, and returns them with the
//                request tag on a valid/ready response channel. Counts
//                completed responses modulo 256.
//  Ports       : clk, rst_n (sync, active low)
//                cmd_*       - request channel (valid/ready, a, b, op, tag)
//                alu_a/b/op  - registered ALU inputs
//                alu_result/alu_zero - combinational ALU outputs
//                rsp_*       - response channel (valid/ready, result, zero,
//                              tag, err)
//                done_count  - completed response count
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_issuer
    import alu_cmd_issuer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  word_t            cmd_a,
    input  word_t            cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output word_t            alu_a,
    output word_t            alu_b,
    output logic [2:0]       alu_op,
    input  word_t            alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output word_t            rsp_result,
    output logic             rsp_zero,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output byte_t            done_count
);

    issuer_state_t    state_q, state_d;
    word_t            alu_a_q, alu_a_d;
    word_t            alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             err_q, err_d;
    logic             rsp_valid_q, rsp_valid_d;
    word_t            rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic             rsp_err_q, rsp_err_d;
    byte_t            done_count_q, done_count_d;

    alu_cmd_t w_push_cmd;
    alu_cmd_t w_head;
    logic     w_fifo_full;
    logic     w_fifo_empty;
    logic     w_fifo_pop;
    logic     w_fifo_push;

    always_comb begin
        w_push_cmd.a   = cmd_a;
        w_push_cmd.b   = cmd_b;
        w_push_cmd.op  = cmd_op;
        w_push_cmd.tag = CMD_TAG_W'(cmd_tag);
    end

    assign cmd_ready   = !w_fifo_full;
    assign w_fifo_push = cmd_valid && cmd_ready;

    sync_fifo #(
        .T     (alu_cmd_t),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_fifo_push),
        .wdata (w_push_cmd),
        .pop   (w_fifo_pop),
        .rdata (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        tag_d        = tag_q;
        err_d        = err_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_err_d    = rsp_err_q;
        done_count_d = done_count_q;
        w_fifo_pop   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_fifo_pop = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Reserved opcodes still occupy an issue slot, but the ALU
                // output is replaced by a fixed zero result.
                rsp_valid_d  = 1'b1;
                rsp_tag_d    = tag_q;
                rsp_err_d    = err_q;
                rsp_result_d = err_q ? '0   : alu_result;
                rsp_zero_d   = err_q ? 1'b1 : alu_zero;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    done_count_d = done_count_q + 8'd1;
                    // Chain straight into the next issue to sustain one
                    // response every two cycles.
                    if (!w_fifo_empty) begin
                        w_fifo_pop = 1'b1;
                        state_d    = S_ISSUE;
                    end else begin
                        state_d    = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // ALU inputs change only when a new command leaves the queue.
        if (w_fifo_pop) begin
            alu_a_d  = w_head.a;
            alu_b_d  = w_head.b;
            alu_op_d = w_head.op;
            tag_d    = TAG_W'(w_head.tag);
            err_d    = is_reserved_op(w_head.op);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            tag_q        <= '0;
            err_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= 1'b0;
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            tag_q        <= tag_d;
            err_q        <= err_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_err_q    <= rsp_err_d;
            done_count_q <= done_count_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_err    = rsp_err_q;
    assign done_count = done_count_q;

endmodule : alu_cmd_issuer
`default_nettype wire
